mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single lower-level memory port (L2 / physical memory) between two requesters:
  - the instruction-cache miss port (read only);
  - the data-side port, fed by the eviction write buffer (reads and write-backs).
- Grants one whole transaction at a time and holds the grant until memory responds.
- Breaks ties round-robin so that neither side starves.
- Sits between the L1 caches/EWB and the cacheline adaptor.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cacheline data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_read_i  in  1  I-side line read request; level, held until i_resp_o.
- i_addr_i  in  ADDR_W  I-side line address.
- i_rdata_o  out  LINE_W  I-side read data, valid with i_resp_o.
- i_resp_o  out  1  I-side done, one-cycle pulse.
- d_read_i  in  1  D-side line read request; level, held until d_resp_o.
- d_write_i  in  1  D-side line write request; level, held until d_resp_o.
- d_addr_i  in  ADDR_W  D-side line address.
- d_wdata_i  in  LINE_W  D-side write data.
- d_rdata_o  out  LINE_W  D-side read data, valid with d_resp_o.
- d_resp_o  out  1  D-side done, one-cycle pulse.
- mem_read_o  out  1  memory read strobe.
- mem_write_o  out  1  memory write strobe.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  LINE_W  memory write data.
- mem_rdata_i  in  LINE_W  memory read data.
- mem_resp_i  in  1  memory done, one-cycle pulse.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. State register plus a 1-bit last_grant register (I=0, D=1).
- Reset values: state=IDLE, last_grant=D (so the first tie after reset goes to I), all outputs 0 (addr/data outputs driven 0).
- IDLE: no memory strobes, no responses.
  - Only I requests -> SERVE_I.
  - Only D (read or write) requests -> SERVE_D.
  - Both request -> grant the side that is not last_grant.
  - Neither requests -> stay in IDLE.
  - last_grant is updated on entry to SERVE_x.
- SERVE_I:
  - mem_read_o=1; mem_addr_o=i_addr_i; mem_wdata_o=0.
  - On mem_resp_i: i_resp_o=1 and i_rdata_o=mem_rdata_i in that same cycle; next state IDLE.
- SERVE_D:
  - mem_read_o=d_read_i; mem_write_o=d_write_i; mem_addr_o=d_addr_i; mem_wdata_o=d_wdata_i.
  - On mem_resp_i: d_resp_o=1 and d_rdata_o=mem_rdata_i in that same cycle; next state IDLE.
- Address and data paths are combinational muxes selected by state. Requesters hold addr/data stable while their request is up.
- Response routing:
  - mem_resp_i reaches only the granted side.
  - rdata outputs are 0 when the matching resp is low.
  - mem_resp_i in IDLE is ignored.
- Latency: request seen in IDLE in cycle N -> memory strobe in cycle N+1 -> resp in the same cycle as mem_resp_i.
- Mandatory IDLE bubble after every response: a requester that just received resp may still show its request level for that cycle, and must not be regranted on it. Back-to-back minimum is one idle cycle between transactions.
- Grant is held until mem_resp_i, even if the granted requester deasserts early (protocol violation). A simulation assertion flags this.
- Fairness: with both sides continuously requesting, grants alternate I, D, I, D. Maximum wait for either side is one transaction plus two cycles.
- d_read_i and d_write_i both high is illegal. An assertion fires, and the request is treated as a write (mem_read_o forced 0).
- rst asserted mid-transaction: next cycle state=IDLE, strobes drop, no resp is issued, and a late mem_resp_i is ignored. The memory side is reset concurrently.

Decomposition:
- Shared package arb_pkg holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D};
  - port_id_t enum {PORT_I=1'b0, PORT_D=1'b1};
  - the localparams for ADDR_W and LINE_W defaults.
- Single module split into control FSM and datapath mux processes; no sub-module is warranted.

Test Plan:
- I-only read, addr 0x0000_0040, mem responds after 5 cycles with 0xAA..AA:
  - mem_read_o high from cycle 1 with mem_addr_o=0x40;
  - i_resp_o one pulse with i_rdata_o=0xAA..AA;
  - d_resp_o stays 0.
- D write, addr 0x0000_1000, wdata 0x1234..:
  - mem_write_o=1, mem_read_o=0, mem_wdata_o matches;
  - d_resp_o pulses in the mem_resp_i cycle;
  - one IDLE cycle follows.
- I and D both request in the same cycle right after reset:
  - I is granted first;
  - D is granted after I's resp plus the IDLE bubble;
  - then both re-request and I is granted again (alternation over 4 transactions).
- D read in progress while I requests at cycle 2:
  - I waits, with no I strobe and no i_resp_o;
  - I is granted after d_resp_o;
  - d_rdata_o matches the memory data only in the resp cycle.
- rst asserted 2 cycles into SERVE_D:
  - all outputs 0 next cycle;
  - a mem_resp_i pulse 1 cycle later produces no resp;
  - a subsequent I request is served normally.
- mem_resp_i pulsed while IDLE with no requests:
  - no resp outputs;
  - state remains IDLE.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
//   arb_state_t : arbiter control state
//   port_id_t   : requester identity, used for the round-robin history bit
package arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_id_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one lower-level memory port between the I-cache miss
// port (read only) and the D-side / eviction write buffer port (read/write).
// One whole transaction is granted at a time and held until mem_resp_i;
// simultaneous requests are resolved round-robin.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_read_i, i_addr_i              I-side request (level) and line address
//   i_rdata_o, i_resp_o             I-side read data / done pulse
//   d_read_i, d_write_i, d_addr_i   D-side request (level), address
//   d_wdata_i                       D-side write data
//   d_rdata_o, d_resp_o             D-side read data / done pulse
//   mem_read_o, mem_write_o         memory strobes
//   mem_addr_o, mem_wdata_o         memory address / write data
//   mem_rdata_i, mem_resp_i         memory read data / done pulse
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate on the request levels seen this cycle
// SERVE_I | I-side read presented to memory until mem_resp_i
// SERVE_D | D-side read or write presented to memory until mem_resp_i
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [LINE_W-1:0] i_rdata_o,
  output logic              i_resp_o,
  input  logic              d_read_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_wdata_i,
  output logic [LINE_W-1:0] d_rdata_o,
  output logic              d_resp_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_resp_i
);

  arb_state_t state_q, state_d;
  port_id_t   last_grant_q, last_grant_d;
  logic       d_req;

  assign d_req = d_read_i | d_write_i;

  // Control: a grant is only ever issued from IDLE, so the cycle after every
  // response is a forced bubble and a stale request level is never regranted.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        // I wins when alone, or on a tie when D had the previous grant.
        if (i_read_i && (!d_req || last_grant_q == PORT_D)) begin
          state_d      = SERVE_I;
          last_grant_d = PORT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = PORT_D;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Datapath: muxes selected by state. Everything is forced low while rst is
  // high so a memory response racing the reset cannot leak to a requester.
  always_comb begin
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    i_resp_o    = 1'b0;
    i_rdata_o   = '0;
    d_resp_o    = 1'b0;
    d_rdata_o   = '0;
    if (!rst) begin
      case (state_q)
        SERVE_I: begin
          mem_read_o = 1'b1;
          mem_addr_o = i_addr_i;
          if (mem_resp_i) begin
            i_resp_o  = 1'b1;
            i_rdata_o = mem_rdata_i;
          end
        end
        SERVE_D: begin
          // Read+write together is illegal; the write takes precedence.
          mem_read_o  = d_read_i & ~d_write_i;
          mem_write_o = d_write_i;
          mem_addr_o  = d_addr_i;
          mem_wdata_o = d_wdata_i;
          if (mem_resp_i) begin
            d_resp_o  = 1'b1;
            d_rdata_o = mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_i_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_I) |-> i_read_i);
  a_d_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == SERVE_D) |-> d_req);
  a_d_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !(d_read_i && d_write_i));
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  localparam int M_IDLE = 0;
  localparam int M_I    = 1;
  localparam int M_D    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read_i;
  logic [AW-1:0] i_addr_i;
  logic [LW-1:0] i_rdata_o;
  logic          i_resp_o;
  logic          d_read_i;
  logic          d_write_i;
  logic [AW-1:0] d_addr_i;
  logic [LW-1:0] d_wdata_i;
  logic [LW-1:0] d_rdata_o;
  logic          d_resp_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o;
  logic [LW-1:0] mem_rdata_i;
  logic          mem_resp_i;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read_i   (i_read_i),
    .i_addr_i   (i_addr_i),
    .i_rdata_o  (i_rdata_o),
    .i_resp_o   (i_resp_o),
    .d_read_i   (d_read_i),
    .d_write_i  (d_write_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_resp_o   (d_resp_o),
    .mem_read_o (mem_read_o),
    .mem_write_o(mem_write_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_resp_i (mem_resp_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: who owns the memory port, and who won the last grant.
  int m_owner = M_IDLE;
  int m_last  = M_D;

  // Random traffic agents.
  bit i_pend, d_pend, d_wr, i_fin, d_fin;
  int mem_cnt;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_model();
    logic          e_mr, e_mw, e_ir, e_dr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wd, e_id, e_dd;
    e_mr = 0; e_mw = 0; e_ir = 0; e_dr = 0;
    e_addr = '0; e_wd = '0; e_id = '0; e_dd = '0;
    if (!rst && m_owner == M_I) begin
      e_mr = 1; e_addr = i_addr_i;
      if (mem_resp_i) begin e_ir = 1; e_id = mem_rdata_i; end
    end else if (!rst && m_owner == M_D) begin
      e_mr = d_read_i && !d_write_i; e_mw = d_write_i;
      e_addr = d_addr_i; e_wd = d_wdata_i;
      if (mem_resp_i) begin e_dr = 1; e_dd = mem_rdata_i; end
    end
    chk("mem_read", LW'(mem_read_o), LW'(e_mr));
    chk("mem_write", LW'(mem_write_o), LW'(e_mw));
    chk("mem_addr", LW'(mem_addr_o), LW'(e_addr));
    chk("mem_wdata", mem_wdata_o, e_wd);
    chk("i_resp", LW'(i_resp_o), LW'(e_ir));
    chk("i_rdata", i_rdata_o, e_id);
    chk("d_resp", LW'(d_resp_o), LW'(e_dr));
    chk("d_rdata", d_rdata_o, e_dd);
  endtask

  // Clock-edge view of the arbitration rules: requesters are ranked with the
  // one that did not win last time first; the first one asking wins.
  task automatic model_edge();
    int  order [2];
    bit  asks  [2];
    if (rst) begin
      m_owner = M_IDLE; m_last = M_D;
      i_pend = 0; d_pend = 0; i_fin = 0; d_fin = 0;
      return;
    end
    if (m_owner == M_IDLE) begin
      order[0] = (m_last == M_D) ? M_I : M_D;
      order[1] = (m_last == M_D) ? M_D : M_I;
      for (int k = 0; k < 2; k++)
        asks[k] = (order[k] == M_I) ? i_read_i : (d_read_i || d_write_i);
      if (asks[0]) m_owner = order[0];
      else if (asks[1]) m_owner = order[1];
      if (m_owner != M_IDLE) begin
        m_last  = m_owner;
        mem_cnt = $urandom_range(0, 4);
      end
    end else if (mem_resp_i) begin
      if (m_owner == M_I) i_fin = 1; else d_fin = 1;
      m_owner = M_IDLE;
    end
  endtask

  task automatic adv();
    check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_stim();
    rst = ($urandom_range(0, 99) == 0);
    if (i_fin) begin i_pend = 0; i_fin = 0; end
    if (d_fin) begin d_pend = 0; d_fin = 0; end
    if (!i_pend && $urandom_range(0, 2) == 0) begin
      i_pend = 1; i_addr_i = $urandom & ~32'h1f;
    end
    if (!d_pend && $urandom_range(0, 2) == 0) begin
      d_pend = 1; d_wr = $urandom_range(0, 1) == 1;
      d_addr_i = $urandom & ~32'h1f; d_wdata_i = rand_line();
    end
    i_read_i  = i_pend;
    d_read_i  = d_pend && !d_wr;
    d_write_i = d_pend && d_wr;
    mem_rdata_i = rand_line();
    if (m_owner != M_IDLE) begin
      if (mem_cnt == 0) mem_resp_i = 1;
      else begin mem_resp_i = 0; mem_cnt--; end
    end else begin
      mem_resp_i = ($urandom_range(0, 5) == 0);
    end
  endtask

  logic [LW-1:0] pat_a, pat_c, pat_w;

  initial begin
    pat_a = {8{32'hAAAA_AAAA}};
    pat_c = {8{32'hCCCC_CCCC}};
    pat_w = {8{32'h1234_5678}};
    rst = 1; i_read_i = 0; i_addr_i = '0; d_read_i = 0; d_write_i = 0;
    d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 0;
    @(negedge clk);
    adv();
    rst = 0;
    #1; chk("reset_mem_read", LW'(mem_read_o), '0);
    chk("reset_i_resp", LW'(i_resp_o), '0);
    adv();

    // I-only read, memory answers on the fifth strobe cycle.
    i_read_i = 1; i_addr_i = 32'h40;
    #1; chk("i_only_idle_read", LW'(mem_read_o), '0);
    adv();
    #1; chk("i_only_strobe", LW'(mem_read_o), LW'(1));
    chk("i_only_addr", LW'(mem_addr_o), LW'(32'h40));
    for (int k = 0; k < 4; k++) begin
      #1; chk("i_only_wait_resp", LW'(i_resp_o), '0);
      adv();
    end
    mem_resp_i = 1; mem_rdata_i = pat_a;
    #1; chk("i_only_resp", LW'(i_resp_o), LW'(1));
    chk("i_only_rdata", i_rdata_o, pat_a);
    chk("i_only_d_resp", LW'(d_resp_o), '0);
    adv();
    i_read_i = 0; mem_resp_i = 0;
    #1; chk("i_only_bubble", LW'(mem_read_o), '0);
    adv();

    // D write.
    d_write_i = 1; d_addr_i = 32'h1000; d_wdata_i = pat_w;
    #1; adv();
    #1; chk("d_wr_write", LW'(mem_write_o), LW'(1));
    chk("d_wr_read", LW'(mem_read_o), '0);
    chk("d_wr_wdata", mem_wdata_o, pat_w);
    adv();
    mem_resp_i = 1;
    #1; chk("d_wr_resp", LW'(d_resp_o), LW'(1));
    adv();
    d_write_i = 0; mem_resp_i = 0;
    #1; chk("d_wr_bubble", LW'(mem_write_o), '0);
    adv();

    // Both requesting continuously right after reset: I, D, I, D.
    rst = 1; #1; adv(); rst = 0;
    i_read_i = 1; i_addr_i = 32'h100; d_read_i = 1; d_addr_i = 32'h200;
    for (int k = 0; k < 4; k++) begin
      #1; chk("rr_bubble", LW'(mem_read_o), '0);
      adv();
      mem_resp_i = 1; mem_rdata_i = rand_line();
      #1; chk("rr_order_addr", LW'(mem_addr_o), LW'((k % 2 == 0) ? 32'h100 : 32'h200));
      chk("rr_order_iresp", LW'(i_resp_o), LW'(k % 2 == 0));
      adv();
      mem_resp_i = 0;
    end
    i_read_i = 0; d_read_i = 0;
    #1; adv();

    // D read in flight, I arrives in cycle 2 and waits.
    d_read_i = 1; d_addr_i = 32'h300;
    #1; adv(); #1; adv();
    i_read_i = 1; i_addr_i = 32'h400;
    #1; chk("dwait_addr", LW'(mem_addr_o), LW'(32'h300));
    chk("dwait_i_resp", LW'(i_resp_o), '0);
    adv();
    mem_rdata_i = pat_c;
    #1; chk("dwait_rdata_low", d_rdata_o, '0);
    adv();
    mem_resp_i = 1;
    #1; chk("dwait_d_resp", LW'(d_resp_o), LW'(1));
    chk("dwait_d_rdata", d_rdata_o, pat_c);
    chk("dwait_no_i_resp", LW'(i_resp_o), '0);
    adv();
    d_read_i = 0; mem_resp_i = 0;
    #1; chk("dwait_bubble", LW'(mem_read_o), '0);
    adv();
    #1; chk("dwait_i_grant", LW'(mem_addr_o), LW'(32'h400));
    mem_resp_i = 1;
    #1; adv();
    i_read_i = 0; mem_resp_i = 0;
    #1; adv();

    // Reset two cycles into a D write; late memory response is dropped.
    d_write_i = 1; d_addr_i = 32'h500; d_wdata_i = pat_w;
    #1; adv(); #1; adv(); #1; adv();
    rst = 1;
    #1; adv();
    rst = 0; d_write_i = 0;
    #1; chk("rst_mid_write", LW'(mem_write_o), '0);
    chk("rst_mid_addr", LW'(mem_addr_o), '0);
    adv();
    mem_resp_i = 1;
    #1; chk("rst_late_d_resp", LW'(d_resp_o), '0);
    chk("rst_late_i_resp", LW'(i_resp_o), '0);
    adv();
    mem_resp_i = 0; i_read_i = 1; i_addr_i = 32'h600;
    #1; adv();
    mem_resp_i = 1; mem_rdata_i = pat_a;
    #1; chk("rst_after_i_addr", LW'(mem_addr_o), LW'(32'h600));
    chk("rst_after_i_resp", LW'(i_resp_o), LW'(1));
    adv();
    i_read_i = 0; mem_resp_i = 0;
    #1; adv();

    // Stray memory response while idle.
    mem_resp_i = 1; mem_rdata_i = pat_c;
    #1; chk("stray_i_resp", LW'(i_resp_o), '0);
    chk("stray_d_resp", LW'(d_resp_o), '0);
    adv();
    mem_resp_i = 0;
    #1; chk("stray_still_idle", LW'(mem_read_o | mem_write_o), '0);
    adv();

    // Randomized traffic.
    i_pend = 0; d_pend = 0; i_fin = 0; d_fin = 0;
    for (int c = 0; c < 4000; c++) begin
      rand_stim();
      #1; adv();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
